// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types and constants for the elastic pipeline stage register.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package pipe_pkg;

    // Encoding is chosen so the state value equals the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam int          A3_W         = 5;

    // M/W stage payload layout inside the opaque data bus (LSB first).
    localparam int MW_MEMREAD_OFF = 0;
    localparam int MW_MEMREAD_W   = 1;
    localparam int MW_ALUOUT_OFF  = 1;
    localparam int MW_ALUOUT_W    = 32;
    localparam int MW_HI_OFF      = 33;
    localparam int MW_HI_W        = 32;
    localparam int MW_LO_OFF      = 65;
    localparam int MW_LO_W        = 32;
    localparam int MW_WDSEL_OFF   = 97;
    localparam int MW_WDSEL_W     = 2;
    localparam int MW_USED_W      = 99;

    function automatic logic [1:0] occ_of(input state_e s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            HALF:    occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Handshake and bus bundle around one elastic pipeline stage.
// Latency: n/a (wires only).
// Backpressure: carries in_ready/out_ready; the stage drives in_ready.
// Ports: flush, in_* (upstream entry + valid), in_ready, out_* (head entry),
// out_ready, occupancy. "slave" is the stage view, "master" the environment.
interface pipe_stage_elastic_if #(
    parameter int DATA_W = 128,
    parameter int PC_W   = 32
);
    import pipe_pkg::*;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic              in_regwrite;
    logic [A3_W-1:0]   in_a3;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic              out_regwrite;
    logic [A3_W-1:0]   out_a3;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    modport master (
        output flush, in_valid, in_pc, in_regwrite, in_a3, in_data, out_ready,
        input  in_ready, out_valid, out_pc, out_regwrite, out_a3, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_pc, in_regwrite, in_a3, in_data, out_ready,
        output in_ready, out_valid, out_pc, out_regwrite, out_a3, out_data, occupancy
    );

endinterface

// File: rtl/pipe_entry_reg.sv
// One stored pipeline entry (PC, RegWrite, A3, payload) with a load enable.
// Latency: 1 cycle from ld to q_*.
// Backpressure: none; holds its contents whenever ld is low.
// Ports: clk, rst_n (async active-low clear to RESET_PC / zeros), ld, d_*, q_*.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int              DATA_W   = 128,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,
    input  logic [PC_W-1:0]   d_pc,
    input  logic              d_regwrite,
    input  logic [A3_W-1:0]   d_a3,
    input  logic [DATA_W-1:0] d_data,
    output logic [PC_W-1:0]   q_pc,
    output logic              q_regwrite,
    output logic [A3_W-1:0]   q_a3,
    output logic [DATA_W-1:0] q_data
);

    logic [PC_W-1:0]   pc_q,       pc_d;
    logic              regwrite_q, regwrite_d;
    logic [A3_W-1:0]   a3_q,       a3_d;
    logic [DATA_W-1:0] data_q,     data_d;

    always_comb begin
        pc_d       = pc_q;
        regwrite_d = regwrite_q;
        a3_d       = a3_q;
        data_d     = data_q;
        if (ld) begin
            pc_d       = d_pc;
            regwrite_d = d_regwrite;
            a3_d       = d_a3;
            data_d     = d_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            regwrite_q <= 1'b0;
            a3_q       <= '0;
            data_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            regwrite_q <= regwrite_d;
            a3_q       <= a3_d;
            data_q     <= data_d;
        end
    end

    assign q_pc       = pc_q;
    assign q_regwrite = regwrite_q;
    assign q_a3       = a3_q;
    assign q_data     = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic MIPS pipeline stage register with valid/ready, flush and optional skid entry.
// Latency: 1 cycle from accepted input to out_valid.
// Backpressure: SKID=1 registers in_ready (drops only when both entries are full);
// SKID=0 gives in_ready = out_ready | ~out_valid.
// Ports: clk, reset (async active-low), bus (slave view of pipe_stage_elastic_if).
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int              DATA_W   = 128,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
    parameter bit              SKID     = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_stage_elastic_if.slave  bus
);

    state_e state_q, state_d;
    logic   in_ready_q, in_ready_d;
    logic   out_regwrite_q, out_regwrite_d;

    logic   out_valid;
    logic   in_ready;
    logic   acc_in;
    logic   acc_out;
    logic   main_ld;
    logic   skid_ld;
    logic   main_from_skid;

    logic [PC_W-1:0]   main_pc,       skid_pc,       main_pc_in;
    logic              main_regwrite, skid_regwrite, main_regwrite_in;
    logic [A3_W-1:0]   main_a3,       skid_a3,       main_a3_in;
    logic [DATA_W-1:0] main_data,     skid_data,     main_data_in;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = SKID ? in_ready_q : (bus.out_ready | ~out_valid);
    assign acc_in    = bus.in_valid & in_ready;
    assign acc_out   = out_valid & bus.out_ready;

    // Flush wins over every transfer: nothing is loaded, so the out_* data
    // fields keep their last values while the entries are discarded.
    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc_in) begin
                        state_d = HALF;
                        main_ld = 1'b1;
                    end
                end
                HALF: begin
                    if (acc_in && acc_out) begin
                        main_ld = 1'b1;
                    end else if (acc_in) begin
                        // Only reachable with a skid entry; without one in_ready
                        // already follows out_ready while main is occupied.
                        if (SKID) begin
                            state_d = FULL;
                            skid_ld = 1'b1;
                        end
                    end else if (acc_out) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (acc_out) begin
                        state_d        = HALF;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        main_pc_in       = main_from_skid ? skid_pc       : bus.in_pc;
        main_regwrite_in = main_from_skid ? skid_regwrite : bus.in_regwrite;
        main_a3_in       = main_from_skid ? skid_a3       : bus.in_a3;
        main_data_in     = main_from_skid ? skid_data     : bus.in_data;
    end

    // RegWrite is qualified with next-state validity before it is registered,
    // so bubbles and flushed entries can never present a write.
    always_comb begin
        in_ready_d     = (state_d != FULL);
        out_regwrite_d = (state_d != EMPTY) &
                         (main_ld ? main_regwrite_in : main_regwrite);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= EMPTY;
            in_ready_q     <= 1'b1;
            out_regwrite_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            out_regwrite_q <= out_regwrite_d;
        end
    end

    pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_main (
        .clk        (clk),
        .rst_n      (reset),
        .ld         (main_ld),
        .d_pc       (main_pc_in),
        .d_regwrite (main_regwrite_in),
        .d_a3       (main_a3_in),
        .d_data     (main_data_in),
        .q_pc       (main_pc),
        .q_regwrite (main_regwrite),
        .q_a3       (main_a3),
        .q_data     (main_data)
    );

    // With SKID=0 skid_ld is constant 0, so this entry reduces to reset constants.
    pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_skid (
        .clk        (clk),
        .rst_n      (reset),
        .ld         (skid_ld),
        .d_pc       (bus.in_pc),
        .d_regwrite (bus.in_regwrite),
        .d_a3       (bus.in_a3),
        .d_data     (bus.in_data),
        .q_pc       (skid_pc),
        .q_regwrite (skid_regwrite),
        .q_a3       (skid_a3),
        .q_data     (skid_data)
    );

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_pc       = main_pc;
    assign bus.out_regwrite = out_regwrite_q;
    assign bus.out_a3       = main_a3;
    assign bus.out_data     = main_data;
    assign bus.occupancy    = occ_of(state_q);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic (SKID=1 and SKID=0 instances).
// Latency: n/a.
// Backpressure: out_ready driven from directed tables and randomly.
module tb_pipe_stage_elastic;

    localparam int DW = 128;
    localparam int PW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic          in_regwrite;
    logic [31:0]   in_pc;
    logic [4:0]    in_a3;
    logic [127:0]  in_data;

    pipe_stage_elastic_if #(.DATA_W(DW), .PC_W(PW)) b1 ();
    pipe_stage_elastic_if #(.DATA_W(DW), .PC_W(PW)) b0 ();

    assign b1.flush = flush;       assign b0.flush = flush;
    assign b1.in_valid = in_valid; assign b0.in_valid = in_valid;
    assign b1.in_pc = in_pc;       assign b0.in_pc = in_pc;
    assign b1.in_regwrite = in_regwrite; assign b0.in_regwrite = in_regwrite;
    assign b1.in_a3 = in_a3;       assign b0.in_a3 = in_a3;
    assign b1.in_data = in_data;   assign b0.in_data = in_data;
    assign b1.out_ready = out_ready; assign b0.out_ready = out_ready;

    pipe_stage_elastic #(.DATA_W(DW), .PC_W(PW), .RESET_PC(32'h0000_3000), .SKID(1'b1))
        u_s1 (.clk(clk), .reset(rst_n), .bus(b1));
    pipe_stage_elastic #(.DATA_W(DW), .PC_W(PW), .RESET_PC(32'h0000_3000), .SKID(1'b0))
        u_s0 (.clk(clk), .reset(rst_n), .bus(b0));

    typedef struct packed {
        logic         vld;
        logic         irdy;
        logic [31:0]  pc;
        logic         rw;
        logic [4:0]   a3;
        logic [127:0] data;
        logic [1:0]   occ;
    } obs_t;

    typedef struct packed {
        logic [31:0]  pc;
        logic         rw;
        logic [4:0]   a3;
        logic [127:0] data;
    } entry_t;

    typedef struct {
        logic        v, r, f, rw;
        logic [31:0] pc;
        logic [4:0]  a3;
        logic        e_vld, e_irdy, e_rw;
        logic [31:0] e_pc;
        logic [4:0]  e_a3;
        logic [1:0]  e_occ;
    } vec_t;

    obs_t o1, o0;
    assign o1 = {b1.out_valid, b1.in_ready, b1.out_pc, b1.out_regwrite, b1.out_a3, b1.out_data, b1.occupancy};
    assign o0 = {b0.out_valid, b0.in_ready, b0.out_pc, b0.out_regwrite, b0.out_a3, b0.out_data, b0.occupancy};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
        chk({tag, ".out_valid"},    128'(a.vld),  128'(e.vld));
        chk({tag, ".in_ready"},     128'(a.irdy), 128'(e.irdy));
        chk({tag, ".out_pc"},       128'(a.pc),   128'(e.pc));
        chk({tag, ".out_regwrite"}, 128'(a.rw),   128'(e.rw));
        chk({tag, ".out_a3"},       128'(a.a3),   128'(e.a3));
        chk({tag, ".out_data"},     a.data,       e.data);
        chk({tag, ".occupancy"},    128'(a.occ),  128'(e.occ));
    endtask

    function automatic logic [127:0] dat_of(input logic [31:0] pc);
        return {pc, ~pc, pc ^ 32'h5A5A_5A5A, pc + 32'd1};
    endfunction

    // ---------------- reference model: bounded FIFO per instance ----------------
    // index 1: SKID=1 (capacity 2, ready = not full); index 0: SKID=0 (capacity 1,
    // ready = empty or downstream ready). disp is the last entry seen at the head.
    entry_t mq   [2][2];
    int     msz  [2];
    entry_t disp [2];

    function automatic logic irdy_m(input int s);
        if (s == 1) return (msz[1] < 2);
        return (out_ready || msz[0] == 0);
    endfunction

    function automatic obs_t model_obs(input int s);
        obs_t e;
        e.vld  = (msz[s] > 0);
        e.irdy = irdy_m(s);
        e.pc   = disp[s].pc;
        e.rw   = e.vld & disp[s].rw;
        e.a3   = disp[s].a3;
        e.data = disp[s].data;
        e.occ  = 2'(msz[s]);
        return e;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            msz[s]  = 0;
            disp[s] = '{pc: 32'h0000_3000, rw: 1'b0, a3: 5'd0, data: 128'd0};
        end
    endtask

    task automatic model_edge();
        entry_t nw;
        logic   rdy;
        logic   pop;
        nw = '{pc: in_pc, rw: in_regwrite, a3: in_a3, data: in_data};
        for (int s = 0; s < 2; s++) begin
            rdy = irdy_m(s);
            if (flush) begin
                msz[s] = 0;
            end else begin
                pop = (msz[s] > 0) && out_ready;
                if (pop) begin
                    mq[s][0] = mq[s][1];
                    msz[s]--;
                end
                if (in_valid && rdy) begin
                    mq[s][msz[s]] = nw;
                    msz[s]++;
                end
            end
            if (msz[s] > 0) disp[s] = mq[s][0];
        end
    endtask

    function automatic vec_t mk(input logic v, r, f, input logic [31:0] pc, input logic rw,
                                input logic [4:0] a3, input logic e_vld, e_irdy,
                                input logic [31:0] e_pc, input logic e_rw,
                                input logic [4:0] e_a3, input logic [1:0] e_occ);
        vec_t t;
        t.v = v; t.r = r; t.f = f; t.pc = pc; t.rw = rw; t.a3 = a3;
        t.e_vld = e_vld; t.e_irdy = e_irdy; t.e_pc = e_pc; t.e_rw = e_rw;
        t.e_a3 = e_a3; t.e_occ = e_occ;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        obs_t rst_exp;
        obs_t e;

        // first accept after reset, then 8-deep back-to-back stream
        tbl.push_back(mk(1,1,0,32'h3004,0,5'd0,  1,1,32'h3004,0,5'd0,2'd1));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1,1,0,32'h3000+32'(4*k),1,5'(k+1), 1,1,32'h3000+32'(4*k),1,5'(k+1),2'd1));
        // stall into skid, ignored offer, drain in order
        tbl.push_back(mk(1,1,0,32'h3008,1,5'd3,  1,1,32'h3008,1,5'd3,2'd1));
        tbl.push_back(mk(1,0,0,32'h300C,1,5'd4,  1,0,32'h3008,1,5'd3,2'd2));
        tbl.push_back(mk(1,0,0,32'h3010,0,5'd5,  1,0,32'h3008,1,5'd3,2'd2));
        tbl.push_back(mk(1,1,0,32'h3010,0,5'd5,  1,1,32'h300C,1,5'd4,2'd1));
        tbl.push_back(mk(1,1,0,32'h3010,0,5'd5,  1,1,32'h3010,0,5'd5,2'd1));
        tbl.push_back(mk(0,1,0,32'h3014,1,5'd6,  0,1,32'h3010,0,5'd5,2'd0));
        // flush while FULL: offered entry dropped, data fields hold
        tbl.push_back(mk(1,0,0,32'h3020,1,5'd7,  1,1,32'h3020,1,5'd7,2'd1));
        tbl.push_back(mk(1,0,0,32'h3024,1,5'd9,  1,0,32'h3020,1,5'd7,2'd2));
        tbl.push_back(mk(1,0,1,32'h3028,1,5'd10, 0,1,32'h3020,0,5'd7,2'd0));
        tbl.push_back(mk(0,1,0,32'h3028,1,5'd10, 0,1,32'h3020,0,5'd7,2'd0));
        // flush while HALF with in_ready high: input still dropped
        tbl.push_back(mk(1,1,0,32'h3030,1,5'd11, 1,1,32'h3030,1,5'd11,2'd1));
        tbl.push_back(mk(1,1,1,32'h3034,1,5'd12, 0,1,32'h3030,0,5'd11,2'd0));
        // bubble with regwrite set, then a real write
        tbl.push_back(mk(0,1,0,32'h3038,1,5'd8,  0,1,32'h3030,0,5'd11,2'd0));
        tbl.push_back(mk(1,1,0,32'h3040,1,5'd8,  1,1,32'h3040,1,5'd8,2'd1));
        // skid entry carries its own regwrite through to main
        tbl.push_back(mk(1,0,0,32'h3044,0,5'd13, 1,0,32'h3040,1,5'd8,2'd2));
        tbl.push_back(mk(0,1,0,32'h3048,1,5'd14, 1,1,32'h3044,0,5'd13,2'd1));
        tbl.push_back(mk(0,1,0,32'h3048,1,5'd14, 0,1,32'h3044,0,5'd13,2'd0));

        rst_exp = '{vld: 1'b0, irdy: 1'b1, pc: 32'h3000, rw: 1'b0, a3: 5'd0, data: 128'd0, occ: 2'd0};

        // reset held with an offered entry
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_regwrite = 1'b1; in_pc = 32'h3004; in_a3 = 5'd0; in_data = dat_of(32'h3004);
        repeat (3) @(posedge clk);
        #1;
        cmp_obs("reset_s1", o1, rst_exp);
        cmp_obs("reset_s0", o0, rst_exp);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            in_valid = tbl[i].v; out_ready = tbl[i].r; flush = tbl[i].f;
            in_pc = tbl[i].pc; in_regwrite = tbl[i].rw; in_a3 = tbl[i].a3;
            in_data = dat_of(tbl[i].pc);
            @(posedge clk);
            #1;
            e = '{vld: tbl[i].e_vld, irdy: tbl[i].e_irdy, pc: tbl[i].e_pc, rw: tbl[i].e_rw,
                  a3: tbl[i].e_a3, data: dat_of(tbl[i].e_pc), occ: tbl[i].e_occ};
            cmp_obs($sformatf("vec%0d", i), o1, e);
        end

        // asynchronous reset while FULL
        in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
        in_pc = 32'h3050; in_regwrite = 1'b1; in_a3 = 5'd1; in_data = dat_of(32'h3050);
        @(posedge clk); #1;
        in_pc = 32'h3054; in_data = dat_of(32'h3054);
        @(posedge clk); #1;
        chk("prereset_occ", 128'(b1.occupancy), 128'd2);
        #2 rst_n = 1'b0;
        #1 cmp_obs("async_reset", o1, rst_exp);
        @(posedge clk); #1;
        cmp_obs("reset_no_accept", o1, rst_exp);
        rst_n = 1'b1;

        // SKID=0: combinational in_ready and reload on simultaneous transfer
        in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h3100; in_data = dat_of(32'h3100);
        #1 chk("s0_empty_ready", 128'(b0.in_ready), 128'd1);
        @(posedge clk); #1;
        chk("s0_first_vld", 128'(b0.out_valid), 128'd1);
        chk("s0_first_pc",  128'(b0.out_pc), 128'h3100);
        out_ready = 1'b0; in_pc = 32'h3104; in_data = dat_of(32'h3104);
        #1 chk("s0_stall_ready", 128'(b0.in_ready), 128'd0);
        @(posedge clk); #1;
        chk("s0_stall_pc",  128'(b0.out_pc), 128'h3100);
        chk("s0_stall_occ", 128'(b0.occupancy), 128'd1);
        out_ready = 1'b1; in_pc = 32'h3108; in_data = dat_of(32'h3108);
        #1 chk("s0_pass_ready", 128'(b0.in_ready), 128'd1);
        @(posedge clk); #1;
        chk("s0_reload_pc",   128'(b0.out_pc), 128'h3108);
        chk("s0_reload_data", b0.out_data, dat_of(32'h3108));
        chk("s0_reload_occ",  128'(b0.occupancy), 128'd1);

        // randomized traffic against the FIFO model, both instances
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid    = ($urandom % 4) != 0;
            out_ready   = ($urandom % 3) != 0;
            flush       = ($urandom % 32) == 0;
            in_pc       = $urandom;
            in_regwrite = $urandom_range(0, 1) == 1;
            in_a3       = 5'($urandom);
            in_data     = {$urandom, $urandom, $urandom, $urandom};
            #1;
            cmp_obs($sformatf("rnd%0d_s1", c), o1, model_obs(1));
            cmp_obs($sformatf("rnd%0d_s0", c), o0, model_obs(0));
            model_edge();
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised next-generation pipeline stage register for the 5-stage MIPS core; replaces the fixed per-stage latches (F/D, D/E, E/M, M/W).
- Adds a valid/ready handshake, a synchronous flush, and an optional 2-entry skid buffer, so stalls propagate without a combinational ready path.
- Carries the PC, a register-write tag (RegWrite, A3) and an opaque payload bus. The payload holds ALU result, memory data, HI/LO, WD-select, or whatever the stage needs.

Parameters:
- DATA_W, 128, width of the opaque payload bus.
- PC_W, 32, width of the PC field.
- RESET_PC, 32'h0000_3000, value loaded into the PC field on reset.
- SKID, 1. 1 = 2-entry skid buffer with registered in_ready; 0 = single-entry, in_ready combinational.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (reset==0 resets)
- flush  in  1  synchronous flush; discards all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry this cycle
- in_pc  in  PC_W  upstream PC
- in_regwrite  in  1  upstream register-write enable
- in_a3  in  5  upstream destination register
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head entry
- out_pc  out  PC_W  head PC
- out_regwrite  out  1  head RegWrite; always 0 when out_valid==0
- out_a3  out  5  head destination register
- out_data  out  DATA_W  head payload
- occupancy  out  2  entries held (0..2); debug and hazard unit

Behaviour:
- Handshake rules:
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
  - Latency from accept to out_valid is 1 cycle.
- Reset (reset==0, asynchronous) sets:
  - state=EMPTY, out_valid=0, out_regwrite=0, occupancy=0
  - out_pc=RESET_PC, out_a3=0, out_data=0
  - skid entry cleared
  - in_ready: 1 when SKID=1 (registered); equals out_ready|~out_valid when SKID=0
- Reset mid-operation discards all entries immediately. No transfer completes in the cycle reset is asserted.
- State machine (SKID=1). Entries are "main" (drives out_*) and "skid". in_ready = (state!=FULL), registered.
  - EMPTY:
    - in_valid -> HALF, load main.
    - Otherwise stay.
  - HALF:
    - in_valid & out_ready -> HALF, main <= input.
    - in_valid & ~out_ready -> FULL, skid <= input.
    - ~in_valid & out_ready -> EMPTY.
    - Otherwise hold.
  - FULL:
    - out_ready -> HALF, main <= skid.
    - Otherwise hold.
    - Inputs are ignored in FULL (in_ready==0).
- SKID=0: only the EMPTY/HALF states exist. in_ready = out_ready | ~out_valid. A simultaneous in/out transfer reloads main.
- Flush:
  - Flush has priority over every transfer: next state=EMPTY, out_valid=0, out_regwrite=0, occupancy=0.
  - out_pc, out_a3 and out_data hold their last values.
  - An input presented in the flush cycle is dropped even if in_ready==1.
- Bubble safety: out_regwrite is registered as stored_regwrite & valid. A bubble or flushed entry never asserts it.
- Stability: while out_valid & ~out_ready, all out_* hold bit-stable.
- occupancy tracks the state: EMPTY=0, HALF=1, FULL=2.
- No entry is lost or duplicated. Ordering is strictly FIFO.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum (EMPTY, HALF, FULL)
  - RESET_PC default
  - payload field offset/width constants per stage (M/W layout: MemRead, ALUout, HI, LO, WDsel)
- One sub-module, pipe_entry_reg: a single entry with load enable and async active-low clear. It is instantiated for main and, under SKID=1, for skid.
- FSM and muxing stay in the top.

Test Plan:
- Reset: hold reset=0 with in_valid=1 -> out_valid=0, out_regwrite=0, out_pc=32'h3000, in_ready=1. Release reset; drive pc=32'h3004 -> appears on out_pc one cycle later, out_valid=1.
- Back-to-back streaming: out_ready=1, PCs 32'h3000..32'h301C at 1/cycle -> identical sequence on out, 1-cycle latency, occupancy stays 1.
- Stall into skid (SKID=1):
  - Drop out_ready with main=32'h3008 and send 32'h300C -> occupancy=2, in_ready=0 next cycle.
  - Offer 32'h3010 (must be ignored).
  - Raise out_ready -> out 32'h3008, then 32'h300C, then accept 32'h3010.
- Flush in FULL: occupancy=2, assert flush with in_valid=1 -> next cycle out_valid=0, out_regwrite=0, occupancy=0, in_ready=1. The input offered during flush never appears.
- Bubble RegWrite: in_regwrite=1, a3=5'd8, in_valid=0 -> out_regwrite stays 0. With in_valid=1 -> out_regwrite=1, out_a3=8.
- SKID=0 build: out_ready=0 with main valid -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 -> main replaced and occupancy stays 1.
